// File: rtl/lint_dbg_arbiter.sv
// Two-to-one lint arbiter sharing one downstream port, with in-order response routing.
// Build option: define LINT_DBG_ARB_JTAG_PRIO_EN for fixed port-0 priority (default round-robin).
module lint_dbg_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned BeWidth        = DATA_WIDTH / 8,
  localparam int unsigned CntWidth       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Requester 0 (JTAG lint master)
  input  logic                  slv0_req_i,
  input  logic [ADDR_WIDTH-1:0] slv0_add_i,
  input  logic                  slv0_wen_i,
  input  logic [DATA_WIDTH-1:0] slv0_wdata_i,
  input  logic [BeWidth-1:0]    slv0_be_i,
  output logic                  slv0_gnt_o,
  output logic                  slv0_r_valid_o,
  output logic [DATA_WIDTH-1:0] slv0_r_rdata_o,
  output logic                  slv0_r_opc_o,
  // Requester 1
  input  logic                  slv1_req_i,
  input  logic [ADDR_WIDTH-1:0] slv1_add_i,
  input  logic                  slv1_wen_i,
  input  logic [DATA_WIDTH-1:0] slv1_wdata_i,
  input  logic [BeWidth-1:0]    slv1_be_i,
  output logic                  slv1_gnt_o,
  output logic                  slv1_r_valid_o,
  output logic [DATA_WIDTH-1:0] slv1_r_rdata_o,
  output logic                  slv1_r_opc_o,
  // Shared downstream port
  output logic                  mst_req_o,
  output logic [ADDR_WIDTH-1:0] mst_add_o,
  output logic                  mst_wen_o,
  output logic [DATA_WIDTH-1:0] mst_wdata_o,
  output logic [BeWidth-1:0]    mst_be_o,
  input  logic                  mst_gnt_i,
  input  logic                  mst_r_valid_i,
  input  logic [DATA_WIDTH-1:0] mst_r_rdata_i,
  input  logic                  mst_r_opc_i,
  // Status
  output logic [CntWidth-1:0]   outstanding_o,
  output logic                  err_o
);

  localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHold0 = 2'd1;
  localparam logic [1:0] StHold1 = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       sel, sel_valid, sel_req;
  logic                       handshake, pop, head;
  logic                       full, empty;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PtrWidth-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]        count_q, count_d;
  logic                       err_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PtrWidth'(1);
  endfunction

  assign full  = (count_q == CntWidth'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Arbitration policy
  // ---------------------------------------------------------------------------
  logic idle_pick;

`ifdef LINT_DBG_ARB_JTAG_PRIO_EN
  assign idle_pick = ~slv0_req_i;
`else
  logic rr_q;

  // rr_q names the port that wins when both request.
  assign idle_pick = (slv0_req_i & slv1_req_i) ? rr_q : slv1_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (handshake) begin
      rr_q <= ~sel;
    end
  end
`endif

  always_comb begin
    sel_valid = 1'b0;
    sel       = 1'b0;
    unique case (state_q)
      StHold0: begin
        sel_valid = 1'b1;
        sel       = 1'b0;
      end
      StHold1: begin
        sel_valid = 1'b1;
        sel       = 1'b1;
      end
      default: begin
        // A full FIFO blocks new selections so the arbiter stays in idle.
        sel_valid = (slv0_req_i | slv1_req_i) & ~full;
        sel       = idle_pick;
      end
    endcase
  end

  assign sel_req   = sel ? slv1_req_i : slv0_req_i;
  assign mst_req_o = sel_valid & sel_req & ~full & ~rst_i;
  assign handshake = mst_req_o & mst_gnt_i;

  assign mst_add_o   = sel ? slv1_add_i   : slv0_add_i;
  assign mst_wen_o   = sel ? slv1_wen_i   : slv0_wen_i;
  assign mst_wdata_o = sel ? slv1_wdata_i : slv0_wdata_i;
  assign mst_be_o    = sel ? slv1_be_i    : slv0_be_i;

  assign slv0_gnt_o = handshake & ~sel;
  assign slv1_gnt_o = handshake & sel;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mst_req_o && !mst_gnt_i) begin
          state_d = sel ? StHold1 : StHold0;
        end
      end
      StHold0, StHold1: begin
        // A requester dropping req while held abandons the transfer.
        if (!sel_req || handshake) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing FIFO (one port-id bit per outstanding transfer)
  // ---------------------------------------------------------------------------
  assign pop  = mst_r_valid_i & ~empty & ~rst_i;
  assign head = id_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({handshake, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (handshake) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (mst_r_valid_i && empty) begin
      err_q <= 1'b1;
    end
  end

  assign slv0_r_valid_o = pop & ~head;
  assign slv1_r_valid_o = pop & head;
  assign slv0_r_rdata_o = slv0_r_valid_o ? mst_r_rdata_i : '0;
  assign slv1_r_rdata_o = slv1_r_valid_o ? mst_r_rdata_i : '0;
  assign slv0_r_opc_o   = slv0_r_valid_o & mst_r_opc_i;
  assign slv1_r_opc_o   = slv1_r_valid_o & mst_r_opc_i;

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_lint_dbg_arbiter.sv
// Scoreboard bench for lint_dbg_arbiter: directed stimulus, queue-based handshake/response checks.
module tb_lint_dbg_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_req = 0, s1_req = 0, s0_wen = 0, s1_wen = 0;
  logic [31:0] s0_add = 0, s1_add = 0, s0_wdata = 0, s1_wdata = 0;
  logic [3:0]  s0_be = 0, s1_be = 0;
  logic        s0_gnt, s1_gnt, s0_rv, s1_rv, s0_opc, s1_opc;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_req, m_wen;
  logic [31:0] m_add, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt = 0, m_rv = 0, m_opc = 0;
  logic [31:0] m_rdata = 0;
  logic [2:0]  outstanding;
  logic        err;

  typedef struct {
    logic        port;
    logic [31:0] val;
  } exp_t;

  exp_t hs_q[$];
  exp_t rsp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  lint_dbg_arbiter #(
    .MAX_OUTSTANDING(4),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .slv0_req_i     (s0_req),
    .slv0_add_i     (s0_add),
    .slv0_wen_i     (s0_wen),
    .slv0_wdata_i   (s0_wdata),
    .slv0_be_i      (s0_be),
    .slv0_gnt_o     (s0_gnt),
    .slv0_r_valid_o (s0_rv),
    .slv0_r_rdata_o (s0_rdata),
    .slv0_r_opc_o   (s0_opc),
    .slv1_req_i     (s1_req),
    .slv1_add_i     (s1_add),
    .slv1_wen_i     (s1_wen),
    .slv1_wdata_i   (s1_wdata),
    .slv1_be_i      (s1_be),
    .slv1_gnt_o     (s1_gnt),
    .slv1_r_valid_o (s1_rv),
    .slv1_r_rdata_o (s1_rdata),
    .slv1_r_opc_o   (s1_opc),
    .mst_req_o      (m_req),
    .mst_add_o      (m_add),
    .mst_wen_o      (m_wen),
    .mst_wdata_o    (m_wdata),
    .mst_be_o       (m_be),
    .mst_gnt_i      (m_gnt),
    .mst_r_valid_i  (m_rv),
    .mst_r_rdata_i  (m_rdata),
    .mst_r_opc_i    (m_opc),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Monitor: compares every handshake and every routed response against the queues.
  always @(negedge clk) begin
    if (m_req && m_gnt) begin
      if (hs_q.size() == 0) fail("hs_unexpected");
      else begin
        mon_e = hs_q.pop_front();
        check("hs_port", 32'(s1_gnt), 32'(mon_e.port));
        check("hs_gnt_onehot", 32'(s0_gnt ^ s1_gnt), 32'd1);
        check("hs_addr", m_add, mon_e.val);
      end
    end
    if (s0_rv || s1_rv) begin
      if (rsp_q.size() == 0) fail("rsp_unexpected");
      else begin
        mon_e = rsp_q.pop_front();
        check("rsp_port", 32'(s1_rv), 32'(mon_e.port));
        check("rsp_onehot", 32'(s0_rv ^ s1_rv), 32'd1);
        check("rsp_data", s1_rv ? s1_rdata : s0_rdata, mon_e.val);
        check("rsp_opc", 32'(s1_rv ? s1_opc : s0_opc), 32'(mon_e.val[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_drv();
    s0_req = 0; s1_req = 0; m_gnt = 0; m_rv = 0; m_rdata = 0; m_opc = 0;
  endtask

  task automatic idle_cycle();
    step(); clear_drv(); settle();
  endtask

  task automatic rsp_cycle(input logic port, input logic [31:0] data);
    step();
    clear_drv();
    m_rv = 1; m_rdata = data; m_opc = data[0];
    rsp_q.push_back('{port, data});
    settle();
  endtask

  task automatic do_reset();
    step(); clear_drv(); rst = 1; settle();
    step(); rst = 0; settle();
  endtask

  initial begin
    logic [3:0] exp_port;
    s0_add = A0; s1_add = A1; s0_wdata = 32'hA0A0_0000; s1_wdata = 32'hB1B1_1111;
    s0_be = 4'hF; s1_be = 4'h3;

    // Reset state
    repeat (2) step();
    settle();
    check("rst_mst_req", 32'(m_req), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err", 32'(err), 0);
    step(); rst = 0; settle();
    check("post_rst_outstanding", 32'(outstanding), 0);
    check("post_rst_gnt", 32'({s0_gnt, s1_gnt, s0_rv, s1_rv}), 0);

    // Single port-0 read, granted immediately, response two cycles later
    step();
    s0_req = 1; s0_add = 32'h1A10_0000; s0_wen = 1; m_gnt = 1;
    hs_q.push_back('{1'b0, 32'h1A10_0000});
    settle();
    check("t1_slv0_gnt", 32'(s0_gnt), 1);
    check("t1_slv1_gnt", 32'(s1_gnt), 0);
    check("t1_wen", 32'(m_wen), 1);
    check("t1_be", 32'(m_be), 32'hF);
    idle_cycle();
    check("t1_outstanding_1", 32'(outstanding), 1);
    rsp_cycle(1'b0, 32'hDEAD_BEEF);
    check("t1_outstanding_still_1", 32'(outstanding), 1);
    idle_cycle();
    check("t1_outstanding_0", 32'(outstanding), 0);
    s0_add = A0;

    // Both ports requesting continuously with an always-granting downstream
    do_reset();
`ifdef LINT_DBG_ARB_JTAG_PRIO_EN
    exp_port = 4'b0000;
`else
    exp_port = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      s0_req = 1; s1_req = 1; m_gnt = 1;
      hs_q.push_back('{exp_port[i], exp_port[i] ? A1 : A0});
      settle();
    end
    idle_cycle();
    check("t2_outstanding_4", 32'(outstanding), 4);
    for (int i = 0; i < 4; i++) rsp_cycle(exp_port[i], 32'h100 + 32'(i));
    idle_cycle();
    step(); s1_req = 1; m_gnt = 1; hs_q.push_back('{1'b1, A1}); settle();
    idle_cycle();
    rsp_cycle(1'b1, 32'h1111);
    idle_cycle();

    // Port 1 held with gnt low for three cycles while port 0 joins
    for (int i = 0; i < 4; i++) begin
      step();
      s1_req = 1; s0_req = (i > 0); m_gnt = (i == 3);
      if (i == 3) hs_q.push_back('{1'b1, A1});
      settle();
      check("t3_hold_req", 32'(m_req), 1);
      check("t3_hold_add", m_add, A1);
      check("t3_hold_wdata", m_wdata, 32'hB1B1_1111);
      check("t3_hold_slv0_gnt", 32'(s0_gnt), 0);
    end
    step(); s1_req = 0; s0_req = 1; m_gnt = 1; hs_q.push_back('{1'b0, A0}); settle();
    idle_cycle();
    rsp_cycle(1'b1, 32'h31);
    rsp_cycle(1'b0, 32'h30);
    idle_cycle();

    // Fill the FIFO, block the fifth request, release it with one response
    for (int i = 0; i < 4; i++) begin
      step();
      s0_req = (i % 2 == 0); s1_req = (i % 2 == 1); m_gnt = 1;
      s0_add = 32'h4000 + 32'(i * 4); s1_add = 32'h4000 + 32'(i * 4);
      hs_q.push_back('{1'(i % 2), 32'h4000 + 32'(i * 4)});
      settle();
    end
    step(); s0_req = 1; s1_req = 0; s0_add = 32'h4010; m_gnt = 1; settle();
    check("t4_full_outstanding", 32'(outstanding), 4);
    check("t4_full_mst_req", 32'(m_req), 0);
    check("t4_full_gnt", 32'(s0_gnt), 0);
    step(); m_rv = 1; m_rdata = 32'h40; m_opc = 0; rsp_q.push_back('{1'b0, 32'h40}); settle();
    check("t4_pop_mst_req", 32'(m_req), 0);
    step(); m_rv = 0; hs_q.push_back('{1'b0, 32'h4010}); settle();
    check("t4_release_req", 32'(m_req), 1);
    check("t4_release_outstanding", 32'(outstanding), 3);
    idle_cycle();
    check("t4_refill_outstanding", 32'(outstanding), 4);
    rsp_cycle(1'b1, 32'h41);
    rsp_cycle(1'b0, 32'h42);
    rsp_cycle(1'b1, 32'h43);
    rsp_cycle(1'b0, 32'h44);
    idle_cycle();
    check("t4_drained", 32'(outstanding), 0);
    s0_add = A0; s1_add = A1;

    // Response with an empty FIFO
    step(); m_rv = 1; m_rdata = 32'hBAD; settle();
    check("t5_no_rvalid", 32'({s0_rv, s1_rv}), 0);
    idle_cycle();
    check("t5_err_set", 32'(err), 1);
    check("t5_outstanding", 32'(outstanding), 0);
    idle_cycle();
    check("t5_err_sticky", 32'(err), 1);
    do_reset();
    check("t5_err_cleared", 32'(err), 0);

    // Reset with two transfers outstanding
    step(); s0_req = 1; m_gnt = 1; hs_q.push_back('{1'b0, A0}); settle();
    step(); s0_req = 0; s1_req = 1; hs_q.push_back('{1'b1, A1}); settle();
    idle_cycle();
    check("t6_outstanding_2", 32'(outstanding), 2);
    step(); rst = 1; s0_req = 1; m_gnt = 1; settle();
    check("t6_rst_mst_req", 32'(m_req), 0);
    check("t6_rst_gnt", 32'({s0_gnt, s1_gnt}), 0);
    step(); rst = 0; clear_drv(); settle();
    check("t6_outstanding_0", 32'(outstanding), 0);
    check("t6_err_0", 32'(err), 0);
    step(); m_rv = 1; m_rdata = 32'h60; settle();
    check("t6_stale_no_rvalid", 32'({s0_rv, s1_rv}), 0);
    idle_cycle();
    check("t6_stale_err", 32'(err), 1);

    check("hs_queue_empty", 32'(hs_q.size()), 0);
    check("rsp_queue_empty", 32'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
